// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions for the display encoder and the capture
// monitor: segment patterns for hex digits 0..F, segment bit positions within
// a {a,b,c,d,e,f,g} pattern, and the capture FSM state type.
package sevenseg_pkg;

  localparam int SEG_W = 7;  // pattern width, {a,b,c,d,e,f,g}
  localparam int CNT_W = 4;  // stability counter width, holds up to 15

  // Bit index of each segment inside a pattern.
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  // Active-high patterns, {a,b,c,d,e,f,g}.
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

  // ST_WAIT: counting a fresh pair; ST_HOLD: pair already committed.
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sevenseg_capture_if.sv
// Display-bus bundle between a seven-segment source and the capture monitor.
//   sel         digit select, one-hot active-high, all-zero = blanking
//   segments    {a,b,c,d,e,f,g}, active-high
//   clr_err     clears the sticky error flag
//   digits_o    recovered nibbles, digit i at [4i+3:4i]
//   valid_mask  bit i set while digit i holds a validly decoded value
//   frame_valid one-cycle pulse once every digit has been captured
//   err         sticky: undecodable pattern or multi-hot select
// master drives the display bus, slave is the capture monitor.
interface sevenseg_capture_if
  import sevenseg_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic [DIGITS-1:0]   sel;
  logic [SEG_W-1:0]    segments;
  logic                clr_err;
  logic [4*DIGITS-1:0] digits_o;
  logic [DIGITS-1:0]   valid_mask;
  logic                frame_valid;
  logic                err;

  modport master (
    output sel, segments, clr_err,
    input  digits_o, valid_mask, frame_valid, err
  );

  modport slave (
    input  sel, segments, clr_err,
    output digits_o, valid_mask, frame_valid, err
  );

endinterface

// File: rtl/seg_decode.sv
// Combinational inverse of the seven-segment encoder.
//   pattern_i  7-bit {a,b,c,d,e,f,g} pattern
//   valid_o    1 when the pattern is one of the sixteen hex glyphs
//   nibble_o   decoded hex value (0 when invalid)
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic             valid_o,
  output logic [3:0]       nibble_o
);

  always_comb begin
    // NOTE: outputs get defaults before the case so no path infers a latch.
    valid_o  = 1'b1;
    nibble_o = 4'h0;
    case (pattern_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Seven-segment display bus monitor. Samples {sel, segments} every cycle,
// requires STABLE identical consecutive samples before accepting a pair,
// then decodes it into the selected digit register. Tracks which digits
// have been seen to pulse frame_valid once per complete frame, and flags
// undecodable patterns or multi-hot selects on a sticky err.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of sevenseg_capture_if (display bus in,
//               recovered digits / status out)
// DIGITS: digit positions. STABLE: samples to accept a pair (2..15).
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  sevenseg_capture_if.slave   bus
);

  localparam int                SW       = DIGITS + SEG_W;
  localparam logic [CNT_W-1:0]  STABLE_C = CNT_W'(STABLE);

  logic [SW-1:0]           sample;
  logic [SW-1:0]           s_q, s_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  cap_state_e              state_q, state_d;
  logic [DIGITS-1:0][3:0]  digits_q, digits_d;
  logic [DIGITS-1:0]       valid_q, valid_d;
  logic [DIGITS-1:0]       seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic [DIGITS-1:0]       s_sel;
  logic [SEG_W-1:0]        s_seg;
  logic                    sel_zero;
  logic                    sel_multi;
  logic                    commit_en;
  logic                    dec_valid;
  logic [3:0]              dec_nibble;

  assign sample = {bus.sel, bus.segments};
  assign s_sel  = s_q[SW-1:SEG_W];
  assign s_seg  = s_q[SEG_W-1:0];

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign sel_zero  = (s_sel == '0);
  assign sel_multi = ((s_sel & (s_sel - DIGITS'(1))) != '0);

  // Commit fires exactly once per stable window: the edge after the count
  // reaches STABLE, and only while not yet in HOLD. It looks only at the
  // registered sample, so an input change on that same edge cannot cancel it.
  assign commit_en = (state_q == ST_WAIT) && (cnt_q == STABLE_C);

  seg_decode u_decode (
    .pattern_i (s_seg),
    .valid_o   (dec_valid),
    .nibble_o  (dec_nibble)
  );

  always_comb begin
    s_d      = s_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    err_d    = err_q;

    // Clear first so an error commit below on the same edge overrides it.
    if (bus.clr_err) err_d = 1'b0;

    if (sample != s_q) begin
      s_d     = sample;
      cnt_d   = CNT_W'(1);
      state_d = ST_WAIT;
    end else begin
      if (cnt_q != STABLE_C) cnt_d = cnt_q + CNT_W'(1);
      if (commit_en) state_d = ST_HOLD;
    end

    if (commit_en && !sel_zero) begin
      if (sel_multi) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (s_sel[i]) begin
            if (dec_valid) begin
              digits_d[i] = dec_nibble;
              valid_d[i]  = 1'b1;
              seen_d[i]   = 1'b1;
            end else begin
              valid_d[i]  = 1'b0;
              seen_d[i]   = 1'b0;
            end
          end
        end
        if (!dec_valid) err_d = 1'b1;
        // Only a commit that completes the set pulses; seen restarts with it.
        if (&seen_d) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end
      end
    end
  end

  // NOTE: the digit registers are reset along with the rest of the state so
  // a reset mid-window leaves no stale digits visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      cnt_q    <= '0;
      state_q  <= ST_WAIT;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign bus.digits_o    = digits_q;
  assign bus.valid_mask  = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Self-checking bench for sevenseg_capture: hand sequences for reset, exact
// commit latency, glitch rejection, clr_err/error collision and reset
// mid-HOLD, plus a table of capture vectors scored through a queue.
module tb_sevenseg_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;
  localparam int HOLD   = STABLE + 2;

  // Glyphs written out independently of the design package.
  localparam logic [6:0] P0   = 7'b1111110;
  localparam logic [6:0] P1   = 7'b0110000;
  localparam logic [6:0] P2   = 7'b1101101;
  localparam logic [6:0] P3   = 7'b1111001;
  localparam logic [6:0] P4   = 7'b0110011;
  localparam logic [6:0] P5   = 7'b1011011;
  localparam logic [6:0] P6   = 7'b1011111;
  localparam logic [6:0] P7   = 7'b1110000;
  localparam logic [6:0] P8   = 7'b1111111;
  localparam logic [6:0] P9   = 7'b1111011;
  localparam logic [6:0] PA   = 7'b1110111;
  localparam logic [6:0] PB   = 7'b0011111;
  localparam logic [6:0] PC   = 7'b1001110;
  localparam logic [6:0] PE   = 7'b1001111;
  localparam logic [6:0] PF   = 7'b1000111;
  localparam logic [6:0] PBAD = 7'b1010101;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_capture_if #(.DIGITS(DIGITS)) bus ();

  sevenseg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int frame_cnt  = 0;
  int commit_cnt = 0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) frame_cnt++;
    if (dut.commit_en === 1'b1) commit_cnt++;
  end

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        clr;
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid;
    logic        exp_err;
    int          exp_frames;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        err;
    int          frames;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] g, input logic c);
    bus.sel      = s;
    bus.segments = g;
    bus.clr_err  = c;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, bus.digits_o, 0);
    check({tag, "_valid"},  bus.valid_mask, 0);
    check({tag, "_err"},    bus.err, 0);
    check({tag, "_frame"},  bus.frame_valid, 0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int quiet_bad;
    int c0;
    int f0;
    exp_t got;

    // Scan 0..3 with 1,2,3,A, rescan, re-commit a seen digit, then errors.
    vecs[0]  = '{4'b0001, P1,    1'b0, 16'h0001, 4'b0001, 1'b0, 0};
    vecs[1]  = '{4'b0010, P2,    1'b0, 16'h0021, 4'b0011, 1'b0, 0};
    vecs[2]  = '{4'b0100, P3,    1'b0, 16'h0321, 4'b0111, 1'b0, 0};
    vecs[3]  = '{4'b1000, PA,    1'b0, 16'hA321, 4'b1111, 1'b0, 1};
    vecs[4]  = '{4'b0001, P1,    1'b0, 16'hA321, 4'b1111, 1'b0, 1};
    vecs[5]  = '{4'b0010, P2,    1'b0, 16'hA321, 4'b1111, 1'b0, 1};
    vecs[6]  = '{4'b0100, P3,    1'b0, 16'hA321, 4'b1111, 1'b0, 1};
    vecs[7]  = '{4'b1000, PA,    1'b0, 16'hA321, 4'b1111, 1'b0, 2};
    vecs[8]  = '{4'b0001, P5,    1'b0, 16'hA325, 4'b1111, 1'b0, 2};
    vecs[9]  = '{4'b0000, 7'h00, 1'b0, 16'hA325, 4'b1111, 1'b0, 2};
    vecs[10] = '{4'b0001, PF,    1'b0, 16'hA32F, 4'b1111, 1'b0, 2};
    vecs[11] = '{4'b0100, PBAD,  1'b0, 16'hA32F, 4'b1011, 1'b1, 2};
    vecs[12] = '{4'b0000, 7'h00, 1'b0, 16'hA32F, 4'b1011, 1'b1, 2};
    vecs[13] = '{4'b0000, 7'h00, 1'b1, 16'hA32F, 4'b1011, 1'b0, 2};
    vecs[14] = '{4'b0011, P8,    1'b0, 16'hA32F, 4'b1011, 1'b1, 2};
    vecs[15] = '{4'b0100, PE,    1'b0, 16'hAE2F, 4'b1111, 1'b1, 2};

    drive(4'b0000, 7'h00, 1'b0);
    rst_n = 1'b0;
    step(3);
    check_all_zero("por");
    rst_n = 1'b1;
    step(STABLE + 2);

    // Basic capture: commit lands exactly STABLE edges after first capture.
    c0 = commit_cnt;
    drive(4'b0001, P0, 1'b0);
    step(STABLE);
    check("basic_before_commit_valid", bus.valid_mask, 4'b0000);
    step(1);
    check("basic_commit_valid", bus.valid_mask, 4'b0001);
    check("basic_commit_digit0", bus.digits_o[3:0], 4'h0);
    step(10 - STABLE - 1);
    check("basic_single_commit", commit_cnt - c0, 1);

    // Glitch: STABLE-1 samples then a change must not commit.
    drive(4'b0010, P1, 1'b0);
    step(STABLE - 1);
    drive(4'b0000, 7'h00, 1'b0);
    step(10);
    check("glitch_valid", bus.valid_mask, 4'b0001);
    check("glitch_digits", bus.digits_o, 16'h0000);

    // Load some state, then reset mid-run and confirm it clears at once.
    drive(4'b0011, P8, 1'b0);
    step(HOLD);
    drive(4'b0001, P8, 1'b0);
    step(HOLD);
    check("preload_err", bus.err, 1);
    check("preload_digits", bus.digits_o, 16'h0008);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_rst");
    drive(4'b0000, 7'h00, 1'b0);
    step(2);
    rst_n = 1'b1;
    f0 = frame_cnt;
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.digits_o != 0 || bus.valid_mask != 0 || bus.err != 0 || bus.frame_valid != 0)
        quiet_bad++;
    end
    check("idle_quiet_cycles", quiet_bad, 0);
    check("idle_no_frame", frame_cnt - f0, 0);

    // Table vectors: expectation queued at drive time, popped after the hold.
    base = frame_cnt;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].sel, vecs[i].seg, vecs[i].clr);
      sb_q.push_back('{vecs[i].exp_digits, vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_frames});
      step(HOLD);
      got = sb_q.pop_front();
      check($sformatf("vec%0d_digits", i), bus.digits_o, got.digits);
      check($sformatf("vec%0d_valid", i),  bus.valid_mask, got.valid);
      check($sformatf("vec%0d_err", i),    bus.err, got.err);
      check($sformatf("vec%0d_frames", i), frame_cnt - base, got.frames);
    end
    check("sb_drained", sb_q.size(), 0);

    // clr_err alone clears; clr_err colliding with an error commit keeps err.
    drive(4'b0100, PE, 1'b1);
    step(1);
    bus.clr_err = 1'b0;
    check("clr_err_clears", bus.err, 0);
    drive(4'b0011, P8, 1'b0);
    step(STABLE);
    check("collide_before", bus.err, 0);
    bus.clr_err = 1'b1;
    step(1);
    bus.clr_err = 1'b0;
    check("collide_set_wins", bus.err, 1);
    check("collide_digits", bus.digits_o, 16'hAE2F);

    // Partial frame, reset mid-HOLD, then a full frame must need all four.
    f0 = frame_cnt;
    drive(4'b0001, P4, 1'b0); step(HOLD);
    drive(4'b0010, P5, 1'b0); step(HOLD);
    drive(4'b0100, P6, 1'b0); step(HOLD);
    check("partial_no_frame", frame_cnt - f0, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("hold_rst");
    step(1);
    rst_n = 1'b1;
    f0 = frame_cnt;
    drive(4'b0001, P7, 1'b0); step(HOLD);
    drive(4'b0010, P9, 1'b0); step(HOLD);
    drive(4'b0100, PB, 1'b0); step(HOLD);
    check("recap_three_no_frame", frame_cnt - f0, 0);
    drive(4'b1000, PC, 1'b0); step(HOLD);
    check("recap_four_frame", frame_cnt - f0, 1);
    check("recap_digits", bus.digits_o, 16'hCB97);
    check("recap_valid", bus.valid_mask, 4'b1111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
